// File: rtl/x9dn_vector_driver.sv
// ---------------------------------------------------------------------------
// x9dn_vector_driver
//
// Sequential stimulus/response engine for the 27-input / 7-output x9dn
// combinational benchmark. Each run applies NUM_VEC pseudo-random vectors
// taken from a 27-bit Fibonacci LFSR (x^27+x^5+x^2+x+1). Every vector is held
// for SETTLE_CYC cycles and then the benchmark response is captured for one
// cycle. Captured responses are folded into a 16-bit MISR signature. The
// Hamming distance between consecutive responses is accumulated as a
// switching-activity figure for power estimation.
//
// Optional feature macro: X9DN_DRV_TOGGLE_EN
//   defined   -> response toggle counter and previous-response register exist
//   undefined -> both are removed and toggle_count is tied to zero; every
//                other output behaves identically cycle-for-cycle
//
// Parameters:
//   NUM_VEC     vectors applied per run (>= 1)
//   SETTLE_CYC  cycles each vector is held before capture (>= 1)
//   CNT_W       width of vec_count / toggle_count (wrap modulo 2^CNT_W)
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         one-cycle run request, honoured only while busy = 0
//   seed          LFSR seed, sampled on an accepted start (0 -> 27'h1)
//   vec_out       vector driven onto benchmark inputs v0..v26
//   vec_valid     vec_out is being applied (SETTLE or CAPTURE)
//   rsp_in        benchmark outputs v27.0..v27.6
//   busy          run in progress
//   done          sticky run-complete flag, cleared by the next accepted start
//   signature     MISR contents
//   vec_count     vectors captured in this run
//   toggle_count  accumulated response Hamming distance
// ---------------------------------------------------------------------------
module x9dn_vector_driver #(
    parameter int NUM_VEC    = 1024,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [26:0]      seed,
    output logic [26:0]      vec_out,
    output logic             vec_valid,
    input  logic [6:0]       rsp_in,
    output logic             busy,
    output logic             done,
    output logic [15:0]      signature,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] toggle_count
);

    // The vector index is kept separate from vec_count because vec_count
    // may be narrower than the run length and wrap; run termination must not
    // depend on it.
    localparam int IDX_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VEC - 1);
    localparam logic [SET_W-1:0] LAST_SETTLE = SET_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SET_W-1:0] settle_cnt;
    logic [IDX_W-1:0] vec_idx;
    logic             start_ok;
    logic             settle_last;
    logic             vec_last;
    logic [26:0]      lfsr_next;
    logic [15:0]      misr_next;

    assign start_ok    = start && (state == IDLE);
    assign settle_last = (settle_cnt == LAST_SETTLE);
    assign vec_last    = (vec_idx == LAST_IDX);

    // Next LFSR vector and next MISR value. The MISR shifts left, applies the
    // CCITT feedback taps when the bit shifted out is set, then folds in the
    // 7-bit response on the low bits.
    always_comb begin
        lfsr_next = {vec_out[25:0], vec_out[26] ^ vec_out[4] ^ vec_out[1] ^ vec_out[0]};
        misr_next = {signature[14:0], 1'b0}
                  ^ (signature[15] ? 16'h1021 : 16'h0000)
                  ^ {9'b0, rsp_in};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs. A run alternates between
    // SETTLE_CYC settle cycles and one capture cycle per vector.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        vec_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                busy      = 1'b1;
                vec_valid = 1'b1;
                if (settle_last) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                busy      = 1'b1;
                vec_valid = 1'b1;
                state_nxt = vec_last ? IDLE : SETTLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Run datapath: vector generation, settle timing, signature compaction
    // and vector counting. Results stay frozen in IDLE until the next
    // accepted start clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_out    <= '0;
            settle_cnt <= '0;
            vec_idx    <= '0;
            signature  <= '0;
            vec_count  <= '0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        // An all-zero seed would lock the LFSR at zero.
                        vec_out    <= (seed == 27'h0) ? 27'h1 : seed;
                        settle_cnt <= '0;
                        vec_idx    <= '0;
                        signature  <= '0;
                        vec_count  <= '0;
                        done       <= 1'b0;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + SET_W'(1);
                end
                CAPTURE: begin
                    signature  <= misr_next;
                    vec_count  <= vec_count + CNT_W'(1);
                    settle_cnt <= '0;
                    if (vec_last) begin
                        done <= 1'b1;
                    end else begin
                        vec_out <= lfsr_next;
                        vec_idx <= vec_idx + IDX_W'(1);
                    end
                end
                default: begin
                    settle_cnt <= '0;
                end
            endcase
        end
    end

`ifdef X9DN_DRV_TOGGLE_EN
    logic [6:0] prev_rsp;
    logic [2:0] rsp_toggles;

    // Number of response bits that differ from the previous captured
    // response.
    always_comb begin
        rsp_toggles = '0;
        for (int i = 0; i < 7; i++) begin
            rsp_toggles = rsp_toggles + {2'b00, rsp_in[i] ^ prev_rsp[i]};
        end
    end

    // Toggle accumulation. The first vector of a run has no predecessor, so
    // it only primes prev_rsp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_rsp     <= '0;
            toggle_count <= '0;
        end else begin
            if (start_ok) begin
                prev_rsp     <= '0;
                toggle_count <= '0;
            end else if (state == CAPTURE) begin
                prev_rsp <= rsp_in;
                if (vec_idx != '0) begin
                    toggle_count <= toggle_count + CNT_W'(rsp_toggles);
                end
            end
        end
    end
`else
    assign toggle_count = '0;
`endif

endmodule

// File: doc/x9dn_vector_driver.md
Name: x9dn_vector_driver

Overview:
- Sequential stimulus/response engine for the 27-in/7-out x9dn combinational benchmark; it drives the benchmark's inputs and collects its outputs.
- Generates pseudo-random input vectors with a 27-bit LFSR and waits a programmable settle time per vector.
- Compacts the 7-bit responses into a 16-bit MISR signature and counts response bit-toggles for switching-activity (power) estimation.
- Sits between the benchmark instance and the training-set power-measurement harness.

Parameters:
- NUM_VEC, 1024: vectors applied per run (>=1).
- SETTLE_CYC, 2: cycles each vector is held before its response is captured (>=1).
- CNT_W, 32: width of vec_count and toggle_count.

Ports:
- clk  input  1  clock; all flops rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle run request; accepted only when busy=0.
- seed  input  27  LFSR seed, sampled on an accepted start.
- vec_out  output  27  vector to benchmark inputs v0..v26 (bit i -> vi).
- vec_valid  output  1  vec_out is being applied (states SETTLE/CAPTURE).
- rsp_in  input  7  benchmark outputs v27.0..v27.6 (bit i -> v27.i).
- busy  output  1  run in progress.
- done  output  1  sticky run-complete flag; cleared on next accepted start.
- signature  output  16  MISR contents.
- vec_count  output  CNT_W  vectors captured this run.
- toggle_count  output  CNT_W  accumulated response Hamming distance.

Behaviour:
- Reset (async, rst_n=0): state IDLE; vec_out=0, vec_valid=0, busy=0, done=0, signature=0, vec_count=0, toggle_count=0, settle counter=0.
- States: IDLE, SETTLE, CAPTURE.
- IDLE + start: next cycle state=SETTLE, busy=1, done=0, vec_valid=1, vec_out=seed (seed==0 substituted by 27'h1 to avoid lock-up), signature=0, vec_count=0, toggle_count=0, settle counter=0.
- SETTLE: counter increments each cycle; when counter==SETTLE_CYC-1 -> CAPTURE. Total SETTLE dwell = SETTLE_CYC cycles.
- CAPTURE (one cycle), sampling rsp_in:
  - signature <= {signature[14:0],1'b0} ^ (signature[15] ? 16'h1021 : 0) ^ {9'b0,rsp_in}.
  - toggle_count += popcount(rsp_in ^ prev_rsp) for every vector except the first; prev_rsp <= rsp_in.
  - vec_count += 1.
  - If this was vector NUM_VEC-1: next state IDLE, busy=0, vec_valid=0, done=1; vec_out holds the last vector.
  - Otherwise: vec_out advances and state returns to SETTLE with counter=0.
- LFSR step: vec_out <= {vec_out[25:0], vec_out[26]^vec_out[4]^vec_out[1]^vec_out[0]} (x^27+x^5+x^2+x+1).
- Per-vector period = SETTLE_CYC+1 cycles. A run occupies NUM_VEC*(SETTLE_CYC+1) busy cycles.
- start while busy=1: ignored, no effect on state or outputs.
- Counters wrap modulo 2^CNT_W with no saturation.
- signature, vec_count and toggle_count hold their final values in IDLE until the next accepted start.
- rst_n asserted mid-run: immediate return to reset values, done=0, no partial signature retained.

Optional Feature:
- Macro X9DN_DRV_TOGGLE_EN.
- Defined: toggle counter and prev_rsp register present, behaving as above.
- Undefined: both are removed, toggle_count is tied to 0, and every other output is unchanged cycle-for-cycle.

Test Plan:
- Reset: rst_n low mid-SETTLE, then released -> all outputs 0, state IDLE, and the next start runs cleanly.
- Seed and vector sequence: NUM_VEC=3, SETTLE_CYC=1, seed=27'h1 -> vec_out 27'h1, 27'h3, 27'h6, each held 2 cycles. done rises 6 cycles after the first SETTLE cycle; vec_count=3.
- Zero seed: seed=0 -> first vec_out=27'h1; sequence identical to the seed=1 case.
- Signature: NUM_VEC=1, rsp_in=7'h55 -> signature=16'h0055, done=1, busy=0 after 1+SETTLE_CYC+1 cycles from start.
- Toggles: NUM_VEC=4, rsp_in alternating 7'h00/7'h7F per vector -> toggle_count=21 (0 when X9DN_DRV_TOGGLE_EN is undefined).
- Busy start and wrap: pulse start mid-run -> ignored; a new start after done -> done clears the next cycle and counters restart from 0. Separately, CNT_W=4 with 17 vectors -> vec_count=1.
